fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 16-bit pipelined MIPS. Owns the PC and issues

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 15 +
 rtl/fetch_stage_pc_register.sv | 26 ++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : FSM states (RUN, WAIT, HOLD, DRAIN), 2-bit encoding
//   NOP_INSTR_DEF : default bubble instruction word
//   PC_INC        : PC increment per fetched instruction (16-bit words)
//   pc_incr()     : modulo-2^16 PC increment
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;
  localparam logic [15:0] PC_INC        = 16'd2;

  // Wraps naturally at 16 bits; never touches pc[0].
  function automatic logic [15:0] pc_incr(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus.
//   req   : fetch request from the fetch stage
//   addr  : fetch address, stable while req=1 and ready=0
//   ready : memory returns rdata this cycle (0-wait allowed)
//   rdata : instruction word, valid when ready=1
// master = fetch stage side, slave = memory side.
interface fetch_stage_if;
  logic        req;
  logic [15:0] addr;
  logic        ready;
  logic [15:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter register.
//   clk, rst : clock, asynchronous active-high reset (loads RESET_PC)
//   load     : load load_pc (takes priority over inc)
//   inc      : advance pc by PC_INC, modulo 2^16
//   load_pc  : redirect target
//   pc       : current PC
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] load_pc,
  output logic [15:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= load_pc;
    else if (inc)  pc <= pc_incr(pc);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 16-bit pipelined MIPS.
// Owns the PC, issues requests over a req/ready bus and presents each fetched
// instruction with its PC+2 to the IF/ID register. Handles hazard stalls and
// branch/jump redirects, including redirects arriving mid-request.
//   clk, rst       : clock, asynchronous active-high reset
//   stall          : hold outputs, do not advance
//   redirect_valid : taken branch/jump this cycle (flush)
//   redirect_pc    : redirect target
//   imem           : instruction-memory bus (master side)
//   instruction    : registered instruction to IF/ID
//   pc_plus_2      : registered PC+2 of that instruction
//   inst_valid     : 1 = real instruction, 0 = bubble
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  fetch_stage_if.master      imem,
  output logic [15:0]        instruction,
  output logic [15:0]        pc_plus_2,
  output logic               inst_valid
);

  fetch_state_t state, state_next;

  logic [15:0] pc;
  logic [15:0] pc_next_seq;
  logic [15:0] drain_addr;
  logic [15:0] skid_instr;
  logic [15:0] skid_pp2;

  logic pc_load, pc_inc;
  logic cap_mem, cap_skid, load_skid, flush, drain_load;

  assign pc_next_seq = pc_incr(pc);

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem.req   = 1'b0;
    imem.addr  = pc;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    cap_mem    = 1'b0;
    cap_skid   = 1'b0;
    load_skid  = 1'b0;
    flush      = 1'b0;
    drain_load = 1'b0;

    unique case (state)
      ST_RUN: begin
        imem.req = !stall && !redirect_valid;
        if (redirect_valid) begin
          pc_load = 1'b1;
          flush   = 1'b1;
        end else if (imem.req && imem.ready) begin
          cap_mem = 1'b1;
          pc_inc  = 1'b1;
        end else if (imem.req) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Request stays up even under redirect so the bus address is stable.
        imem.req = 1'b1;
        if (redirect_valid) begin
          pc_load = 1'b1;
          flush   = 1'b1;
          if (imem.ready) begin
            state_next = ST_RUN;
          end else begin
            // Old-address transaction must still complete; remember it.
            drain_load = 1'b1;
            state_next = ST_DRAIN;
          end
        end else if (imem.ready) begin
          pc_inc = 1'b1;
          if (stall) begin
            load_skid  = 1'b1;
            state_next = ST_HOLD;
          end else begin
            cap_mem    = 1'b1;
            state_next = ST_RUN;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_load    = 1'b1;
          flush      = 1'b1;
          state_next = ST_RUN;
        end else if (!stall) begin
          cap_skid   = 1'b1;
          state_next = ST_RUN;
        end
      end

      ST_DRAIN: begin
        imem.req  = 1'b1;
        imem.addr = drain_addr;
        if (redirect_valid) begin
          pc_load = 1'b1;
          flush   = 1'b1;
        end
        if (imem.ready) state_next = ST_RUN;
      end

      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      pc_plus_2   <= '0;
      inst_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pp2    <= '0;
      drain_addr  <= '0;
    end else begin
      if (flush) begin
        instruction <= NOP_INSTR;
        inst_valid  <= 1'b0;
      end else if (cap_mem) begin
        instruction <= imem.rdata;
        pc_plus_2   <= pc_next_seq;
        inst_valid  <= 1'b1;
      end else if (cap_skid) begin
        instruction <= skid_instr;
        pc_plus_2   <= skid_pp2;
        inst_valid  <= 1'b1;
      end
      if (load_skid) begin
        skid_instr <= imem.rdata;
        skid_pp2   <= pc_next_seq;
      end
      if (drain_load) drain_addr <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID words are queued when the
// memory returns data; a negedge monitor pops one whenever a new valid
// instruction appears on the outputs.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instruction;
  logic [15:0] pc_plus_2;
  logic        inst_valid;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .instruction    (instruction),
    .pc_plus_2      (pc_plus_2),
    .inst_valid     (inst_valid)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pp2;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] p);
    exp_t e;
    e.instr = i;
    e.pp2   = p;
    exp_q.push_back(e);
  endtask

  // Monitor: a new valid output word consumes one scoreboard entry.
  logic [32:0] prev_out = '0;
  always @(negedge clk) begin
    logic [32:0] cur;
    exp_t        e;
    cur = {instruction, pc_plus_2, inst_valid};
    if (!rst && inst_valid && cur != prev_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got instr %h pc_plus_2 %h, expected none", instruction, pc_plus_2);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", instruction, e.instr);
        check("out_pc_plus_2", pc_plus_2, e.pp2);
      end
    end
    prev_out = cur;
  end

  logic [15:0] t1_rdata [4];

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_bus.ready = 1'b0;
    imem_bus.rdata = '0;
    t1_rdata[0] = 16'h1111;
    t1_rdata[1] = 16'h2222;
    t1_rdata[2] = 16'h3333;
    t1_rdata[3] = 16'h4444;

    // Reset state
    neg();
    check("rst_instr", instruction, 16'h0000);
    check("rst_pc_plus_2", pc_plus_2, 16'h0000);
    check("rst_valid", {15'd0, inst_valid}, 16'd0);
    cyc();
    rst = 1'b0;

    // 1: 0-wait streaming, addrs 0,2,4,6
    for (int unsigned i = 0; i < 4; i++) begin
      imem_bus.ready = 1'b1;
      imem_bus.rdata = t1_rdata[i];
      push(t1_rdata[i], 16'(2 * i + 2));
      neg();
      check("t1_addr", imem_bus.addr, 16'(2 * i));
      check("t1_req", {15'd0, imem_bus.req}, 16'd1);
      cyc();
    end

    // 2: redirect to 0x0010, memory ready delayed 3 cycles
    imem_bus.ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    cyc();
    redirect_valid = 1'b0;
    neg();
    check("t2_flush_valid", {15'd0, inst_valid}, 16'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      neg();
      check("t2_wait_addr", imem_bus.addr, 16'h0010);
      check("t2_wait_req", {15'd0, imem_bus.req}, 16'd1);
      cyc();
    end
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 16'h5555;
    push(16'h5555, 16'h0012);
    neg();
    check("t2_ready_addr", imem_bus.addr, 16'h0010);
    cyc();

    // 3: stall raised in WAIT when ready arrives -> skid, then release
    imem_bus.ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    cyc();
    redirect_valid = 1'b0;
    cyc();                        // RUN -> WAIT on 0x0010
    stall          = 1'b1;
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 16'h6666;
    push(16'h6666, 16'h0012);
    cyc();                        // WAIT -> HOLD
    imem_bus.ready = 1'b0;
    neg();
    check("t3_hold_instr", instruction, 16'h0000);
    check("t3_hold_valid", {15'd0, inst_valid}, 16'd0);
    check("t3_hold_req", {15'd0, imem_bus.req}, 16'd0);
    cyc();
    neg();
    check("t3_hold2_valid", {15'd0, inst_valid}, 16'd0);
    stall = 1'b0;
    cyc();                        // skid -> outputs
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 16'h7777;
    push(16'h7777, 16'h0014);
    neg();
    check("t3_next_addr", imem_bus.addr, 16'h0012);
    check("t3_next_req", {15'd0, imem_bus.req}, 16'd1);
    cyc();

    // 4: redirect to 0x0100 while waiting on 0x0020 -> DRAIN
    imem_bus.ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0020;
    cyc();
    redirect_valid = 1'b0;
    cyc();                        // RUN -> WAIT on 0x0020
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    neg();
    check("t4_wait_addr", imem_bus.addr, 16'h0020);
    cyc();                        // WAIT -> DRAIN
    redirect_valid = 1'b0;
    neg();
    check("t4_drain_addr", imem_bus.addr, 16'h0020);
    check("t4_drain_req", {15'd0, imem_bus.req}, 16'd1);
    check("t4_drain_valid", {15'd0, inst_valid}, 16'd0);
    cyc();
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 16'hDEAD;    // discarded
    neg();
    check("t4_drain2_addr", imem_bus.addr, 16'h0020);
    cyc();                        // DRAIN -> RUN
    imem_bus.ready = 1'b0;
    neg();
    check("t4_after_valid", {15'd0, inst_valid}, 16'd0);
    check("t4_after_instr", instruction, 16'h0000);
    check("t4_new_addr", imem_bus.addr, 16'h0100);
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 16'h8888;
    push(16'h8888, 16'h0102);
    cyc();

    // 5: redirect and stall together
    imem_bus.ready = 1'b0;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    cyc();
    redirect_valid = 1'b0;
    neg();
    check("t5_instr", instruction, 16'h0000);
    check("t5_valid", {15'd0, inst_valid}, 16'd0);
    check("t5_pc", imem_bus.addr, 16'h0200);
    check("t5_req", {15'd0, imem_bus.req}, 16'd0);
    cyc();
    stall          = 1'b0;
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 16'h9999;
    push(16'h9999, 16'h0202);
    cyc();

    // 6: wrap at 0xFFFE, then async reset mid-WAIT
    imem_bus.ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    cyc();
    redirect_valid = 1'b0;
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 16'hABCD;
    push(16'hABCD, 16'h0000);
    neg();
    check("t6_addr", imem_bus.addr, 16'hFFFE);
    cyc();
    imem_bus.ready = 1'b0;
    neg();
    check("t6_wrap_addr", imem_bus.addr, 16'h0000);
    cyc();                        // RUN -> WAIT on 0x0000
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_instr", instruction, 16'h0000);
    check("t6_rst_pc_plus_2", pc_plus_2, 16'h0000);
    check("t6_rst_valid", {15'd0, inst_valid}, 16'd0);
    check("t6_rst_addr", imem_bus.addr, 16'h0000);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check("scoreboard_left", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
